// File: rtl/bsv_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bsv_fifo_pkg
// Shared helpers for the sized FIFO family:
//   clog2          - ceiling log2, usable in constant expressions
//   fifo_params_ok - elaboration-time sanity check of the FIFO parameters
//   dout_sel_e     - source selection for the registered head-of-queue output
// No ports (package).
// -----------------------------------------------------------------------------
package bsv_fifo_pkg;

   // Where the output register is reloaded from on the next edge.
   typedef enum logic [1:0] {
      LD_HOLD = 2'd0,   // keep current D_OUT
      LD_DIN  = 2'd1,   // bypass: D_IN goes straight to D_OUT
      LD_RING = 2'd2    // pop: ring[head] moves into D_OUT
   } dout_sel_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Depth must leave at least a 2-entry ring, the thresholds must be
   // reachable, and COUNT must be wide enough to hold the full depth.
   function automatic bit fifo_params_ok(input int depth, input int cntr_w,
                                         input int afull, input int aempty);
      return (depth >= 3) && (afull <= depth) && (aempty < depth) &&
             (cntr_w >= clog2(depth + 1));
   endfunction

endpackage

// File: rtl/sized_fifo_lvl_ram.sv
// -----------------------------------------------------------------------------
// sized_fifo_lvl_ram
// Ring storage behind the FIFO output register. One synchronous write port,
// one asynchronous read port, no reset, so it can map onto distributed RAM.
// Ports:
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address (tail pointer)
//   wdata_i  - write data
//   raddr_i  - read address (head pointer)
//   rdata_o  - combinational read data
// -----------------------------------------------------------------------------
module sized_fifo_lvl_ram #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 3,
   parameter int AW    = 2
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sized_fifo_lvl.sv
// -----------------------------------------------------------------------------
// sized_fifo_lvl
// Sized FIFO with registered head-of-queue output, occupancy count, almost
// full/empty levels and sticky overflow/underflow flags. Capacity is the output
// register plus a (p2depth-1)-entry ring held in sized_fifo_lvl_ram.
// Ports:
//   CLK          - rising-edge clock
//   RST          - asynchronous active-high reset
//   CLR          - synchronous flush (wins over ENQ/DEQ, D_OUT held)
//   D_IN, ENQ    - enqueue data / request
//   DEQ          - dequeue request
//   D_OUT        - registered head-of-queue data
//   FULL_N       - low when COUNT == p2depth
//   EMPTY_N      - high when COUNT > 0
//   COUNT        - occupancy
//   ALMOST_FULL  - COUNT >= p4afull
//   ALMOST_EMPTY - COUNT <= p5aempty
//   OVF, UNF     - sticky dropped-ENQ / ignored-DEQ flags
// -----------------------------------------------------------------------------
module sized_fifo_lvl
   import bsv_fifo_pkg::*;
#(
   parameter int p1width      = 1,
   parameter int p2depth      = 4,
   parameter int p3cntr_width = 3,
   parameter int p4afull      = 3,
   parameter int p5aempty     = 1,
   parameter int guarded      = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CLR,
   input  logic [p1width-1:0]      D_IN,
   input  logic                    ENQ,
   input  logic                    DEQ,
   output logic [p1width-1:0]      D_OUT,
   output logic                    FULL_N,
   output logic                    EMPTY_N,
   output logic [p3cntr_width-1:0] COUNT,
   output logic                    ALMOST_FULL,
   output logic                    ALMOST_EMPTY,
   output logic                    OVF,
   output logic                    UNF
);

   localparam int RING = p2depth - 1;
   localparam int PW   = (clog2(RING) < 1) ? 1 : clog2(RING);
   localparam int CW   = p3cntr_width;

   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(p2depth);
   localparam logic [CW-1:0] AFULL_C  = CW'(p4afull);
   localparam logic [CW-1:0] AEMPTY_C = CW'(p5aempty);

   if (!fifo_params_ok(p2depth, p3cntr_width, p4afull, p5aempty)) begin : g_param_err
      $fatal(1, "sized_fifo_lvl: illegal parameters (p2depth=%0d p3cntr_width=%0d p4afull=%0d p5aempty=%0d)",
             p2depth, p3cntr_width, p4afull, p5aempty);
   end

   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [p1width-1:0] dout_q, dout_d;
   logic               full_n_q, full_n_d;
   logic               empty_n_q, empty_n_d;
   logic               afull_q, afull_d;
   logic               aempty_q, aempty_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   logic               acc_enq, acc_deq, ring_we;
   logic [p1width-1:0] ring_rdata;
   dout_sel_e          dout_sel;

   // Pointers run over RING entries, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RING - 1)) ? '0 : p + PW'(1);
   endfunction

   sized_fifo_lvl_ram #(
      .WIDTH (p1width),
      .DEPTH (RING),
      .AW    (PW)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (ring_we),
      .waddr_i (tail_q),
      .wdata_i (D_IN),
      .raddr_i (head_q),
      .rdata_o (ring_rdata)
   );

   always_comb begin
      // When full and unguarded, a simultaneous DEQ frees the slot this ENQ uses.
      acc_enq  = ENQ && (full_n_q || (DEQ && empty_n_q && (guarded == 0)));
      acc_deq  = DEQ && empty_n_q;

      count_d  = count_q;
      head_d   = head_q;
      tail_d   = tail_q;
      dout_sel = LD_HOLD;
      ring_we  = 1'b0;
      ovf_d    = ovf_q | (ENQ && !acc_enq);
      unf_d    = unf_q | (DEQ && !empty_n_q);

      if (acc_enq && !acc_deq)      count_d = count_q + ONE_C;
      else if (!acc_enq && acc_deq) count_d = count_q - ONE_C;

      // Ring holds COUNT-1 entries; refill D_OUT from it only when it has data,
      // otherwise an enqueue into an empty (or just-emptied) output bypasses it.
      if (acc_deq && (count_q > ONE_C)) begin
         dout_sel = LD_RING;
         head_d   = ptr_inc(head_q);
      end else if (acc_enq && (!empty_n_q || acc_deq)) begin
         dout_sel = LD_DIN;
      end

      if (acc_enq && empty_n_q && !(acc_deq && (count_q == ONE_C))) begin
         ring_we = 1'b1;
         tail_d  = ptr_inc(tail_q);
      end

      if (CLR) begin
         count_d  = '0;
         head_d   = '0;
         tail_d   = '0;
         dout_sel = LD_HOLD;
         ring_we  = 1'b0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end

      // Flags come from the next COUNT so they line up with COUNT itself.
      full_n_d  = (count_d != DEPTH_C);
      empty_n_d = (count_d != '0);
      afull_d   = (count_d >= AFULL_C);
      aempty_d  = (count_d <= AEMPTY_C);

      unique case (dout_sel)
         LD_DIN:  dout_d = D_IN;
         LD_RING: dout_d = ring_rdata;
         default: dout_d = dout_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         dout_q    <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;   // COUNT=0 is always <= p5aempty
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         dout_q    <= dout_d;
         full_n_q  <= full_n_d;
         empty_n_q <= empty_n_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (!RST) begin
         if (ENQ && !acc_enq)
            $display("%m: warning: ENQ dropped while full at %0t", $time);
         if (DEQ && !empty_n_q)
            $display("%m: warning: DEQ ignored while empty at %0t", $time);
      end
   end
`endif

   assign D_OUT        = dout_q;
   assign FULL_N       = full_n_q;
   assign EMPTY_N      = empty_n_q;
   assign COUNT        = count_q;
   assign ALMOST_FULL  = afull_q;
   assign ALMOST_EMPTY = aempty_q;
   assign OVF          = ovf_q;
   assign UNF          = unf_q;

endmodule

// File: tb/tb_sized_fifo_lvl.sv
// -----------------------------------------------------------------------------
// tb_sized_fifo_lvl
// Self-checking bench for sized_fifo_lvl (depth 5, 8-bit data, guarded).
// A queue-based reference model tracks contents, sticky flags and the held
// head value; each test task compares DUT outputs against it or constants.
// -----------------------------------------------------------------------------
module tb_sized_fifo_lvl;

   localparam int W       = 8;
   localparam int DEPTH   = 5;
   localparam int AF      = 3;
   localparam int AE      = 1;
   localparam int GUARDED = 1;

   localparam logic [16:0] RESET_STATUS = {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         CLR = 1'b0;
   logic         ENQ = 1'b0;
   logic         DEQ = 1'b0;
   logic [W-1:0] D_IN = '0;
   logic [W-1:0] D_OUT;
   logic         FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, OVF, UNF;
   logic [2:0]   COUNT;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mq[$];
   logic [7:0] m_dout = 8'h00;
   bit         m_ovf  = 1'b0;
   bit         m_unf  = 1'b0;

   always #5 CLK = ~CLK;

   sized_fifo_lvl #(
      .p1width      (W),
      .p2depth      (DEPTH),
      .p3cntr_width (3),
      .p4afull      (AF),
      .p5aempty     (AE),
      .guarded      (GUARDED)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .CLR          (CLR),
      .D_IN         (D_IN),
      .ENQ          (ENQ),
      .DEQ          (DEQ),
      .D_OUT        (D_OUT),
      .FULL_N       (FULL_N),
      .EMPTY_N      (EMPTY_N),
      .COUNT        (COUNT),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .OVF          (OVF),
      .UNF          (UNF)
   );

   function automatic logic [16:0] got();
      return {COUNT, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, OVF, UNF, D_OUT};
   endfunction

   function automatic logic [16:0] expv();
      int n;
      n = mq.size();
      return {3'(n), (n != DEPTH), (n != 0), (n >= AF), (n <= AE), m_ovf, m_unf, m_dout};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // Drive one cycle, advance the model at the edge, then settle #1 past it.
   task automatic apply(input bit e, input bit d, input bit c, input logic [7:0] din);
      bit full, empty, a_enq, a_deq;
      ENQ = e; DEQ = d; CLR = c; D_IN = din;
      @(posedge CLK);
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         a_enq = e && (!full || (d && !empty && (GUARDED == 0)));
         a_deq = d && !empty;
         if (e && !a_enq) m_ovf = 1'b1;
         if (d && empty)  m_unf = 1'b1;
         if (a_deq) void'(mq.pop_front());
         if (a_enq) mq.push_back(din);
         if (mq.size() > 0) m_dout = mq[0];
      end
      #1;
      ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_tests++;
      if (got() !== RESET_STATUS) begin
         n_fail++;
         $display("FAIL reset_state got=%h required=%h", got(), RESET_STATUS);
      end
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      apply(0, 0, 1, 8'h00);
      for (int i = 1; i <= DEPTH; i++) begin
         apply(1, 0, 0, 8'(i));
         n_tests++;
         if (got() !== expv()) begin
            n_fail++;
            $display("FAIL fill[%0d] status got=%h required=%h", i, got(), expv());
         end
         n_tests++;
         if ({COUNT, ALMOST_FULL} !== {3'(i), (i >= 3)}) begin
            n_fail++;
            $display("FAIL fill_level[%0d] count/afull got=%0d/%0b required=%0d/%0b",
                     i, COUNT, ALMOST_FULL, i, (i >= 3));
         end
      end
      n_tests++;
      if (FULL_N !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full_n got=%0b required=0", FULL_N);
      end
   endtask

   task automatic test_overflow_drain();
      apply(1, 0, 0, 8'hAA);
      n_tests++;
      if ({OVF, COUNT} !== {1'b1, 3'd5}) begin
         n_fail++;
         $display("FAIL overflow ovf/count got=%0b/%0d required=1/5", OVF, COUNT);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         n_tests++;
         if (D_OUT !== 8'(i)) begin
            n_fail++;
            $display("FAIL drain[%0d] d_out got=%h required=%h", i, D_OUT, 8'(i));
         end
         apply(0, 1, 0, 8'h00);
      end
      n_tests++;
      if (got() !== expv()) begin
         n_fail++;
         $display("FAIL drain_empty status got=%h required=%h", got(), expv());
      end
   endtask

   task automatic test_bypass_count1();
      apply(0, 0, 1, 8'h00);
      apply(1, 0, 0, 8'h11);
      n_tests++;
      if ({D_OUT, EMPTY_N, COUNT} !== {8'h11, 1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL first_enq d_out/empty_n/count got=%h/%0b/%0d required=11/1/1", D_OUT, EMPTY_N, COUNT);
      end
      apply(1, 1, 0, 8'h33);
      n_tests++;
      if ({D_OUT, EMPTY_N, COUNT} !== {8'h33, 1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL count1_enq_deq d_out/empty_n/count got=%h/%0b/%0d required=33/1/1", D_OUT, EMPTY_N, COUNT);
      end
      apply(0, 1, 0, 8'h00);
      n_tests++;
      if (got() !== expv()) begin
         n_fail++;
         $display("FAIL count1_ring_empty status got=%h required=%h", got(), expv());
      end
   endtask

   task automatic test_stream_wrap();
      apply(0, 0, 1, 8'h00);
      for (int i = 0; i < 3; i++) apply(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 20; i++) begin
         apply(1, 1, 0, 8'($urandom));
         n_tests++;
         if (got() !== expv() || COUNT !== 3'd3) begin
            n_fail++;
            $display("FAIL stream[%0d] status got=%h required=%h", i, got(), expv());
         end
      end
   endtask

   task automatic test_underflow_clr();
      apply(0, 0, 1, 8'h00);
      apply(0, 1, 0, 8'h00);
      n_tests++;
      if ({UNF, COUNT} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL underflow unf/count got=%0b/%0d required=1/0", UNF, COUNT);
      end
      apply(0, 0, 1, 8'h00);
      n_tests++;
      if ({UNF, COUNT, EMPTY_N, FULL_N} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL clr_unf unf/count/empty_n/full_n got=%0b/%0d/%0b/%0b required=0/0/0/1",
                  UNF, COUNT, EMPTY_N, FULL_N);
      end
   endtask

   task automatic test_guarded_edges();
      // ENQ+DEQ while empty: enqueue accepted, underflow still flagged.
      apply(0, 0, 1, 8'h00);
      apply(1, 1, 0, 8'h5C);
      n_tests++;
      if ({UNF, COUNT, D_OUT} !== {1'b1, 3'd1, 8'h5C}) begin
         n_fail++;
         $display("FAIL empty_enq_deq unf/count/d_out got=%0b/%0d/%h required=1/1/5c", UNF, COUNT, D_OUT);
      end
      // Full + ENQ+DEQ on a guarded FIFO: dequeue only, enqueue dropped.
      for (int i = 0; i < 4; i++) apply(1, 0, 0, 8'($urandom));
      apply(1, 1, 0, 8'hEE);
      n_tests++;
      if ({OVF, COUNT} !== {1'b1, 3'd4} || got() !== expv()) begin
         n_fail++;
         $display("FAIL guarded_full status got=%h required=%h", got(), expv());
      end
   endtask

   task automatic test_async_reset();
      apply(0, 0, 1, 8'h00);
      for (int i = 0; i < 4; i++) apply(1, 0, 0, 8'(8'h40 + i));
      #2;
      RST = 1'b1;
      #1;
      n_tests++;
      if (got() !== RESET_STATUS) begin
         n_fail++;
         $display("FAIL async_reset status got=%h required=%h", got(), RESET_STATUS);
      end
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      apply(1, 0, 0, 8'h5A);
      n_tests++;
      if ({D_OUT, COUNT, EMPTY_N} !== {8'h5A, 3'd1, 1'b1} || got() !== expv()) begin
         n_fail++;
         $display("FAIL post_reset_enq status got=%h required=%h", got(), expv());
      end
   endtask

   task automatic test_random();
      bit e, d, c;
      apply(0, 0, 1, 8'h00);
      for (int i = 0; i < 400; i++) begin
         // Alternate fill-biased and drain-biased phases to visit full and empty.
         if (((i / 40) % 2) == 0) begin
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0);
         end else begin
            e = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) != 0);
         end
         c = ($urandom_range(0, 63) == 0);
         apply(e, d, c, 8'($urandom));
         n_tests++;
         if (got() !== expv()) begin
            n_fail++;
            $display("FAIL random[%0d] e=%0b d=%0b c=%0b status got=%h required=%h",
                     i, e, d, c, got(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow_drain();
      test_bypass_count1();
      test_stream_wrap();
      test_underflow_clr();
      test_guarded_edges();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
